// File: rtl/reg_file_32x32_pkg.sv
// Shared register-file constants and types, also used by decode and write-back.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // True when a write to addr would actually land in storage (register 0 is read-only).
  function automatic logic is_writable(input addr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_file_32x32_reg32_en.sv
// One enabled register with asynchronous clear; the storage cell for registers 1..NREGS-1.
module reg32_en #(
  parameter int W = regfile_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d on an enabled edge; reset clears without waiting for the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 2-read / 1-write register file with hardwired-zero register 0 and
// write-to-read bypass so write-back and decode can share a cycle.
module reg_file_32x32 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(regfile_pkg::ZERO_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // Register 0 has no storage; it is a constant in the read mux.
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      reg32_en #(.W(DATA_W)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en && (wr_addr == ADDR_W'(gi))),
        .d     (wr_data),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Bypass compares depend only on addresses, so they resolve in parallel with the read muxes.
  always_comb begin
    wr_live = wr_en && (wr_addr != ZERO_ADDR);
    byp1    = wr_live && (wr_addr == rd_addr1);
    byp2    = wr_live && (wr_addr == rd_addr2);
  end

  // 32:1 read muxes over stored state.
  always_comb begin
    stored1 = regs[rd_addr1];
    stored2 = regs[rd_addr2];
  end

  // Final 2:1 bypass select; reads are forced to zero while reset is held.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rst_n) begin
      rd_data1 = byp1 ? wr_data : stored1;
      rd_data2 = byp2 ? wr_data : stored2;
    end
  end

endmodule
